hs32_mem_arb: RTL and testbench

Parametrised N-channel internal memory arbiter, the successor to the two-channel IMA. It sits between the CPU-side requesters (fetch, load/store, DMA, debug) and the single external memory port. It serialises requests under fixed-priority or round-robin arbitration, returns read data and a one-cycle ack to the granted channel, and aborts hung transactions with an error ack after a programmable timeout.

---
 rtl/hs32_mem_arb.sv | 155 +++++++++++++++
 tb/tb_hs32_mem_arb.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hs32_mem_arb.sv
// hs32_mem_arb: N-channel arbiter onto a single external memory port with
// fixed-priority or round-robin grant and a timeout abort that returns an error ack.
module hs32_mem_arb #(
   parameter int NCH = 4,
   parameter int AW  = 32,
   parameter int DW  = 32,
   parameter int RR  = 1,
   parameter int TMO = 255
) (
   input  logic              clk,
   input  logic              reset,
   output logic [AW-1:0]     addr,
   output logic              rw,
   input  logic [DW-1:0]     din,
   output logic [DW-1:0]     dout,
   output logic              wvalid,
   input  logic              done,
   output logic              busy,
   input  logic [NCH-1:0]    req,
   input  logic [NCH-1:0]    rw_ch,
   input  logic [NCH*AW-1:0] addr_ch,
   input  logic [NCH*DW-1:0] dtw_ch,
   output logic [DW-1:0]     dtr,
   output logic [NCH-1:0]    ack,
   output logic              err,
   output logic [NCH-1:0]    gnt
);

   localparam int IW = $clog2(NCH);
   localparam int CW = (TMO < 2) ? 1 : $clog2(TMO);
   localparam logic [IW-1:0] LAST_CH  = IW'(NCH - 1);
   localparam logic [IW:0]   NCH_W    = (IW + 1)'(NCH);
   localparam logic [CW-1:0] TMO_LAST = CW'((TMO == 0) ? 0 : TMO - 1);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

   state_t           state_q;
   logic [AW-1:0]    addr_q;
   logic             rw_q;
   logic [DW-1:0]    dout_q;
   logic             wvalid_q;
   logic             busy_q;
   logic [DW-1:0]    dtr_q;
   logic [NCH-1:0]   ack_q;
   logic             err_q;
   logic [NCH-1:0]   gnt_q;
   logic [IW-1:0]    gidx_q;
   logic [IW-1:0]    ptr_q;
   logic [IW-1:0]    ptr_d;
   logic [CW-1:0]    cnt_q;

   logic             sel_vld;
   logic [IW-1:0]    sel_idx;
   logic [IW:0]      cand;

   logic [AW-1:0]    ch_addr [NCH];
   logic [DW-1:0]    ch_wdat [NCH];

   for (genvar i = 0; i < NCH; i++) begin : g_unpack
      assign ch_addr[i] = addr_ch[i*AW +: AW];
      assign ch_wdat[i] = dtw_ch[i*DW +: DW];
   end

   // Scan channels starting at ptr (RR) or at 0 (fixed); first requester wins.
   always_comb begin
      // NOTE: every always_comb output gets a default first, so no latch can be inferred.
      sel_vld = 1'b0;
      sel_idx = '0;
      cand    = '0;
      for (int k = 0; k < NCH; k++) begin
         cand = (RR != 0) ? ({1'b0, ptr_q} + (IW + 1)'(k)) : (IW + 1)'(k);
         if (cand >= NCH_W) cand = cand - NCH_W;
         if (!sel_vld && req[cand[IW-1:0]]) begin
            sel_vld = 1'b1;
            sel_idx = cand[IW-1:0];
         end
      end
   end

   assign ptr_d = (gidx_q == LAST_CH) ? '0 : gidx_q + IW'(1);

   // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         addr_q   <= '0;
         rw_q     <= 1'b0;
         dout_q   <= '0;
         wvalid_q <= 1'b0;
         busy_q   <= 1'b0;
         dtr_q    <= '0;
         ack_q    <= '0;
         err_q    <= 1'b0;
         gnt_q    <= '0;
         gidx_q   <= '0;
         ptr_q    <= '0;
         cnt_q    <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (sel_vld) begin
                  addr_q   <= ch_addr[sel_idx];
                  rw_q     <= rw_ch[sel_idx];
                  dout_q   <= ch_wdat[sel_idx];
                  wvalid_q <= rw_ch[sel_idx];
                  gnt_q    <= NCH'(1) << sel_idx;
                  gidx_q   <= sel_idx;
                  busy_q   <= 1'b1;
                  cnt_q    <= '0;
                  state_q  <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (done) begin
                  if (!rw_q) dtr_q <= din;
                  ack_q    <= gnt_q;
                  err_q    <= 1'b0;
                  wvalid_q <= 1'b0;
                  if (RR != 0) ptr_q <= ptr_d;
                  state_q  <= S_RESP;
               end else if (TMO != 0 && cnt_q == TMO_LAST) begin
                  // Hung transaction: abort with an error ack and zeroed read data.
                  dtr_q    <= '0;
                  ack_q    <= gnt_q;
                  err_q    <= 1'b1;
                  wvalid_q <= 1'b0;
                  if (RR != 0) ptr_q <= ptr_d;
                  state_q  <= S_RESP;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            S_RESP: begin
               ack_q   <= '0;
               err_q   <= 1'b0;
               gnt_q   <= '0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign addr   = addr_q;
   assign rw     = rw_q;
   assign dout   = dout_q;
   assign wvalid = wvalid_q;
   assign busy   = busy_q;
   assign dtr    = dtr_q;
   assign ack    = ack_q;
   assign err    = err_q;
   assign gnt    = gnt_q;

endmodule

// File: tb/tb_hs32_mem_arb.sv
// Directed bench for hs32_mem_arb: a round-robin instance (dut_rr) and a
// fixed-priority instance (dut_fp) share all inputs; each scenario checks one of them.
module tb_hs32_mem_arb;

   localparam int NCH = 4;
   localparam int AW  = 32;
   localparam int DW  = 32;

   logic              clk = 1'b0;
   logic              reset;
   logic              done;
   logic [DW-1:0]     din;
   logic [NCH-1:0]    req;
   logic [NCH-1:0]    rw_ch;
   logic [NCH*AW-1:0] addr_ch;
   logic [NCH*DW-1:0] dtw_ch;

   logic [AW-1:0]  a_addr, b_addr;
   logic           a_rw, b_rw;
   logic [DW-1:0]  a_dout, b_dout;
   logic           a_wvalid, b_wvalid;
   logic           a_busy, b_busy;
   logic [DW-1:0]  a_dtr, b_dtr;
   logic [NCH-1:0] a_ack, b_ack;
   logic           a_err, b_err;
   logic [NCH-1:0] a_gnt, b_gnt;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   hs32_mem_arb #(.NCH(NCH), .AW(AW), .DW(DW), .RR(1), .TMO(4)) dut_rr (
      .clk(clk), .reset(reset), .addr(a_addr), .rw(a_rw), .din(din), .dout(a_dout),
      .wvalid(a_wvalid), .done(done), .busy(a_busy), .req(req), .rw_ch(rw_ch),
      .addr_ch(addr_ch), .dtw_ch(dtw_ch), .dtr(a_dtr), .ack(a_ack), .err(a_err), .gnt(a_gnt)
   );

   hs32_mem_arb #(.NCH(NCH), .AW(AW), .DW(DW), .RR(0), .TMO(4)) dut_fp (
      .clk(clk), .reset(reset), .addr(b_addr), .rw(b_rw), .din(din), .dout(b_dout),
      .wvalid(b_wvalid), .done(done), .busy(b_busy), .req(req), .rw_ch(rw_ch),
      .addr_ch(addr_ch), .dtw_ch(dtw_ch), .dtr(b_dtr), .ack(b_ack), .err(b_err), .gnt(b_gnt)
   );

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic set_ch(input int ch, input logic [AW-1:0] a, input logic [DW-1:0] w, input logic dir);
      addr_ch[ch*AW +: AW] = a;
      dtw_ch[ch*DW +: DW]  = w;
      rw_ch[ch]            = dir;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   // Advance to the first cycle in BUSY (busy high, no ack) of the chosen instance.
   task automatic wait_grant(input bit on_fp, input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < 12 && !seen; i++) begin
         tick();
         seen = on_fp ? (b_busy && b_ack == '0) : (a_busy && a_ack == '0);
      end
      n_checks++;
      if (!seen) $display("FAIL %s: no grant seen within 12 cycles", tag);
      else n_pass++;
   endtask

   task automatic test_reset();
      reset = 1'b1; req = '0; rw_ch = '0; addr_ch = '0; dtw_ch = '0; done = 1'b0; din = '0;
      repeat (2) tick();
      reset = 1'b0;
      tick();
      n_checks++;
      if ({a_busy, a_gnt, a_ack, a_err, a_wvalid, a_rw} !== '0)
         $display("FAIL rst_ctrl: got %b expected 0", {a_busy, a_gnt, a_ack, a_err, a_wvalid, a_rw});
      else n_pass++;
      n_checks++;
      if ({a_addr, a_dout, a_dtr} !== '0)
         $display("FAIL rst_data: got %h expected 0", {a_addr, a_dout, a_dtr});
      else n_pass++;

      set_ch(1, 32'h0000_3000, 32'hA5A5_5A5A, 1'b1);
      req = 4'b0010;
      wait_grant(1'b0, "rst_first_grant");
      n_checks++;
      if ({a_gnt, a_addr, a_wvalid} !== {4'b0010, 32'h0000_3000, 1'b1})
         $display("FAIL rst_busy: got gnt=%b addr=%h wvalid=%b expected 0010/00003000/1", a_gnt, a_addr, a_wvalid);
      else n_pass++;

      reset = 1'b1;
      tick();
      n_checks++;
      if ({a_busy, a_gnt, a_ack, a_err, a_wvalid, a_rw} !== '0)
         $display("FAIL rst_mid_ctrl: got %b expected 0", {a_busy, a_gnt, a_ack, a_err, a_wvalid, a_rw});
      else n_pass++;
      n_checks++;
      if ({a_addr, a_dout, a_dtr} !== '0)
         $display("FAIL rst_mid_data: got %h expected 0", {a_addr, a_dout, a_dtr});
      else n_pass++;
      tick();
      n_checks++;
      if (a_ack !== 4'b0000) $display("FAIL rst_no_ack: got %b expected 0000", a_ack);
      else n_pass++;

      reset = 1'b0;
      wait_grant(1'b0, "rst_regrant");
      n_checks++;
      if (a_gnt !== 4'b0010) $display("FAIL rst_regrant_gnt: got %b expected 0010", a_gnt);
      else n_pass++;
      done = 1'b1;
      tick();
      n_checks++;
      if ({a_ack, a_err} !== {4'b0010, 1'b0}) $display("FAIL rst_regrant_ack: got %b/%b expected 0010/0", a_ack, a_err);
      else n_pass++;
      req = '0; done = 1'b0;
      tick();
   endtask

   task automatic test_single_read();
      set_ch(2, 32'h0000_1000, 32'h0, 1'b0);
      req = 4'b0100;
      wait_grant(1'b0, "rd_grant");
      n_checks++;
      if ({a_addr, a_wvalid, a_rw, a_gnt} !== {32'h0000_1000, 1'b0, 1'b0, 4'b0100})
         $display("FAIL rd_busy: got addr=%h wvalid=%b rw=%b gnt=%b expected 00001000/0/0/0100", a_addr, a_wvalid, a_rw, a_gnt);
      else n_pass++;
      tick();
      n_checks++;
      if ({a_busy, a_ack} !== {1'b1, 4'b0000}) $display("FAIL rd_wait: got busy=%b ack=%b expected 1/0000", a_busy, a_ack);
      else n_pass++;
      done = 1'b1; din = 32'hDEAD_BEEF;
      tick();
      n_checks++;
      if ({a_ack, a_err, a_dtr} !== {4'b0100, 1'b0, 32'hDEAD_BEEF})
         $display("FAIL rd_ack: got ack=%b err=%b dtr=%h expected 0100/0/deadbeef", a_ack, a_err, a_dtr);
      else n_pass++;
      req = '0; done = 1'b0; din = '0;
      tick();
      n_checks++;
      if ({a_ack, a_gnt, a_busy, a_addr} !== {4'b0000, 4'b0000, 1'b0, 32'h0000_1000})
         $display("FAIL rd_idle: got ack=%b gnt=%b busy=%b addr=%h expected 0000/0000/0/00001000", a_ack, a_gnt, a_busy, a_addr);
      else n_pass++;
   endtask

   task automatic test_write();
      set_ch(0, 32'h0000_2000, 32'h1234_5678, 1'b1);
      req = 4'b0001;
      wait_grant(1'b0, "wr_grant");
      n_checks++;
      if ({a_dout, a_wvalid, a_rw, a_gnt} !== {32'h1234_5678, 1'b1, 1'b1, 4'b0001})
         $display("FAIL wr_busy: got dout=%h wvalid=%b rw=%b gnt=%b expected 12345678/1/1/0001", a_dout, a_wvalid, a_rw, a_gnt);
      else n_pass++;
      din = 32'hBADC_0DE0;
      tick();
      n_checks++;
      if (a_wvalid !== 1'b1) $display("FAIL wr_wvalid_hold: got %b expected 1", a_wvalid);
      else n_pass++;
      done = 1'b1;
      tick();
      n_checks++;
      if ({a_ack, a_err, a_wvalid, a_dtr} !== {4'b0001, 1'b0, 1'b0, 32'hDEAD_BEEF})
         $display("FAIL wr_ack: got ack=%b err=%b wvalid=%b dtr=%h expected 0001/0/0/deadbeef", a_ack, a_err, a_wvalid, a_dtr);
      else n_pass++;
      req = '0; done = 1'b0; din = '0;
      tick();
      n_checks++;
      if ({a_ack, a_dout} !== {4'b0000, 32'h1234_5678})
         $display("FAIL wr_idle: got ack=%b dout=%h expected 0000/12345678", a_ack, a_dout);
      else n_pass++;
   endtask

   task automatic test_fixed_priority();
      logic [NCH-1:0] exp;
      pulse_reset();
      for (int i = 0; i < NCH; i++) set_ch(i, 32'h100 * (i + 1), 32'h0, 1'b0);
      req = 4'b1111;
      for (int g = 0; g < NCH; g++) begin
         exp = 4'b0001 << g;
         wait_grant(1'b1, "fp_grant");
         n_checks++;
         if (b_gnt !== exp) $display("FAIL fp_gnt[%0d]: got %b expected %b", g, b_gnt, exp);
         else n_pass++;
         done = 1'b1;
         tick();
         n_checks++;
         if (b_ack !== exp) $display("FAIL fp_ack[%0d]: got %b expected %b", g, b_ack, exp);
         else n_pass++;
         req[g] = 1'b0; done = 1'b0;
         tick();
         n_checks++;
         if (b_busy !== 1'b0) $display("FAIL fp_idle_gap[%0d]: got busy=%b expected 0", g, b_busy);
         else n_pass++;
      end
   endtask

   task automatic test_round_robin();
      int order [6] = '{0, 1, 3, 0, 1, 3};
      logic [NCH-1:0] exp;
      logic [DW-1:0]  rdat;
      pulse_reset();
      set_ch(0, 32'h0000_0A00, 32'h0, 1'b0);
      set_ch(1, 32'h0000_0B00, 32'h0, 1'b0);
      set_ch(3, 32'h0000_0D00, 32'h0, 1'b0);
      req = 4'b1011;
      for (int k = 0; k < 6; k++) begin
         exp  = 4'b0001 << order[k];
         rdat = 32'h1000_0000 + DW'(k);
         wait_grant(1'b0, "rr_grant");
         n_checks++;
         if (a_gnt !== exp) $display("FAIL rr_gnt[%0d]: got %b expected %b", k, a_gnt, exp);
         else n_pass++;
         done = 1'b1; din = rdat;
         tick();
         n_checks++;
         if ({a_ack, a_dtr} !== {exp, rdat}) $display("FAIL rr_ack[%0d]: got %b/%h expected %b/%h", k, a_ack, a_dtr, exp, rdat);
         else n_pass++;
         req[order[k]] = 1'b0; done = 1'b0;
         tick();
         req[order[k]] = 1'b1;
      end
      req = '0;
      tick();
   endtask

   task automatic test_timeout();
      pulse_reset();
      set_ch(2, 32'h0000_0C00, 32'h0, 1'b0);
      req = 4'b0100;
      wait_grant(1'b0, "to_pre_grant");
      done = 1'b1; din = 32'hCAFE_F00D;
      tick();
      n_checks++;
      if (a_dtr !== 32'hCAFE_F00D) $display("FAIL to_pre_dtr: got %h expected cafef00d", a_dtr);
      else n_pass++;
      req = '0; done = 1'b0; din = '0;
      tick();

      set_ch(3, 32'h0000_4000, 32'h0, 1'b0);
      req = 4'b1000;
      wait_grant(1'b0, "to_grant");
      n_checks++;
      if (a_gnt !== 4'b1000) $display("FAIL to_gnt: got %b expected 1000", a_gnt);
      else n_pass++;
      for (int c = 2; c <= 4; c++) begin
         tick();
         n_checks++;
         if ({a_busy, a_ack} !== {1'b1, 4'b0000}) $display("FAIL to_wait[%0d]: got busy=%b ack=%b expected 1/0000", c, a_busy, a_ack);
         else n_pass++;
      end
      tick();
      n_checks++;
      if ({a_ack, a_err, a_dtr} !== {4'b1000, 1'b1, 32'h0})
         $display("FAIL to_abort: got ack=%b err=%b dtr=%h expected 1000/1/00000000", a_ack, a_err, a_dtr);
      else n_pass++;
      req = '0;
      tick();
      n_checks++;
      if ({a_ack, a_err, a_busy} !== {4'b0000, 1'b0, 1'b0}) $display("FAIL to_idle: got %b expected 0", {a_ack, a_err, a_busy});
      else n_pass++;

      set_ch(1, 32'h0000_5000, 32'h0, 1'b0);
      req = 4'b0010;
      wait_grant(1'b0, "to_next_grant");
      n_checks++;
      if ({a_gnt, a_addr} !== {4'b0010, 32'h0000_5000}) $display("FAIL to_next_busy: got %b/%h expected 0010/00005000", a_gnt, a_addr);
      else n_pass++;
      done = 1'b1; din = 32'h600D_F00D;
      tick();
      n_checks++;
      if ({a_ack, a_err, a_dtr} !== {4'b0010, 1'b0, 32'h600D_F00D})
         $display("FAIL to_next_ack: got ack=%b err=%b dtr=%h expected 0010/0/600df00d", a_ack, a_err, a_dtr);
      else n_pass++;
      req = '0; done = 1'b0; din = '0;
      tick();
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_write();
      test_fixed_priority();
      test_round_robin();
      test_timeout();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule
